// File: rtl/axi_led_pwm_ctrl.sv
// ============================================================================
// axi_led_pwm_ctrl
// ----------------------------------------------------------------------------
// AXI4-Lite slave driving NUM_LED active-high LED outputs. Each channel has a
// DUTY_W-bit PWM brightness and an off / steady / blink mode. One prescaler,
// shared by all channels, generates the blink phase.
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 CTRL          bit0 global enable, bit1 irq enable (IRQ build only)
//   0x04 MODE          2 bits per channel: 00 off, 01 steady, 10 blink, 11 off
//   0x08 BLINK_PERIOD  [BLINK_W-1:0]
//   0x0C STATUS        bit0 blink phase, bit1 irq pending (IRQ build only, W1C)
//   0x10+4i DUTY[i]    [DUTY_W-1:0]
// Unmapped words answer SLVERR and read as 0.
//
// Optional feature macro: AXI_LED_PWM_CTRL_IRQ_EN
//   defined   -> IRQ output port, CTRL bit1, STATUS bit1 with W1C clear
//   undefined -> no IRQ port, CTRL bit1 and STATUS bit1 read 0
//
// Ports:
//   ACLK, ARESETN             clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*           AXI4-Lite write address / data / response
//   S_AXI_AR*/R*              AXI4-Lite read address / data
//   LED[NUM_LED-1:0]          registered LED drive
//   IRQ                       registered level interrupt (IRQ build only)
// ============================================================================
module axi_led_pwm_ctrl #(
    parameter int NUM_LED            = 4,
    parameter int DUTY_W             = 8,
    parameter int BLINK_W            = 24,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
    output logic                            IRQ,
`endif
    output logic [NUM_LED-1:0]              LED
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int MODE_W = 2 * NUM_LED;
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
    localparam int CTRL_W = 2;
`else
    localparam int CTRL_W = 1;
`endif

    localparam logic [WORD_W-1:0] WORD_CTRL   = WORD_W'(0);
    localparam logic [WORD_W-1:0] WORD_MODE   = WORD_W'(1);
    localparam logic [WORD_W-1:0] WORD_BLINK  = WORD_W'(2);
    localparam logic [WORD_W-1:0] WORD_STATUS = WORD_W'(3);
    localparam logic [WORD_W-1:0] WORD_LAST   = WORD_W'(3 + NUM_LED);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [DUTY_W-1:0] CNT_MAX = '1;

    // Replace the bytes selected by strb, keep the rest.
    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0]   old_val,
        input logic [DW-1:0]   new_val,
        input logic [DW/8-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < DW / 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0]  ctrl_reg,         ctrl_next;
    logic [MODE_W-1:0]  mode_reg,         mode_next;
    logic [BLINK_W-1:0] blink_period_reg, blink_period_next;
    logic [BLINK_W-1:0] presc_reg,        presc_next;
    logic               phase_reg,        phase_next;
    logic [DUTY_W-1:0]  cnt_reg,          cnt_next;
    logic [NUM_LED-1:0] led_reg,          led_next;
    logic               bvalid_reg,       bvalid_next;
    logic [1:0]         bresp_reg,        bresp_next;
    logic               rvalid_reg,       rvalid_next;
    logic [1:0]         rresp_reg,        rresp_next;
    logic [DW-1:0]      rdata_reg,        rdata_next;

    logic [NUM_LED*DUTY_W-1:0] duty_flat;

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    logic              wr_accept, rd_accept;
    logic              wr_hit, rd_hit;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic              bp_wr;
    logic [DW-1:0]     rd_data;
    logic              unused_addr_lsbs;

    assign wr_word   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_hit    = (wr_word <= WORD_LAST);
    assign rd_hit    = (rd_word <= WORD_LAST);
    assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_reg;
    assign rd_accept = S_AXI_ARVALID && !rvalid_reg;
    assign bp_wr     = wr_accept && (wr_word == WORD_BLINK);

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_ARREADY = rd_accept;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign LED           = led_reg;

    // ------------------------------------------------------------------
    // Optional interrupt: pending bit set on every blink toggle, W1C.
    // ------------------------------------------------------------------
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
    logic irq_pend_reg, irq_pend_next;
    logic irq_reg,      irq_next;
    logic blink_tick, irq_clr;

    assign blink_tick = (blink_period_reg != '0) && !bp_wr &&
                        (presc_reg == blink_period_reg - 1'b1);
    assign irq_clr    = wr_accept && (wr_word == WORD_STATUS) &&
                        S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    always_comb begin
        irq_pend_next = irq_pend_reg;
        // A toggle in the same cycle as the clear keeps the bit set.
        if (blink_tick) begin
            irq_pend_next = 1'b1;
        end else if (irq_clr) begin
            irq_pend_next = 1'b0;
        end
        irq_next = irq_pend_reg && ctrl_reg[1];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_pend_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            irq_pend_reg <= irq_pend_next;
            irq_reg      <= irq_next;
        end
    end

    assign IRQ = irq_reg;
`endif

    // ------------------------------------------------------------------
    // Per-channel duty register, shadow duty and LED term
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_ch
            logic [DUTY_W-1:0] duty_reg,   duty_next;
            logic [DUTY_W-1:0] shadow_reg, shadow_next;
            logic [1:0]        ch_mode;
            logic              pwm_on;

            always_comb begin
                duty_next = duty_reg;
                if (wr_accept && (wr_word == WORD_W'(4 + gi))) begin
                    duty_next = DUTY_W'(byte_merge(DW'(duty_reg), S_AXI_WDATA, S_AXI_WSTRB));
                end
                // Only pick up a new duty at the end of a PWM period so a
                // period is never cut short or stretched.
                shadow_next = (cnt_reg == CNT_MAX) ? duty_reg : shadow_reg;
            end

            assign ch_mode = mode_reg[2*gi +: 2];
            assign pwm_on  = (cnt_reg < shadow_reg);
            assign led_next[gi] = ctrl_reg[0] &&
                                  (((ch_mode == 2'b01) && pwm_on) ||
                                   ((ch_mode == 2'b10) && pwm_on && phase_reg));
            assign duty_flat[gi*DUTY_W +: DUTY_W] = duty_reg;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    duty_reg   <= '0;
                    shadow_reg <= '0;
                end else begin
                    duty_reg   <= duty_next;
                    shadow_reg <= shadow_next;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read data mux (sees pre-write register values)
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (rd_word)
            WORD_CTRL:   rd_data = DW'(ctrl_reg);
            WORD_MODE:   rd_data = DW'(mode_reg);
            WORD_BLINK:  rd_data = DW'(blink_period_reg);
            WORD_STATUS: begin
                rd_data[0] = phase_reg;
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
                rd_data[1] = irq_pend_reg;
`endif
            end
            default: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    if (rd_word == WORD_W'(4 + i)) begin
                        rd_data = DW'(duty_flat[i*DUTY_W +: DUTY_W]);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic for the shared registers
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_next         = ctrl_reg;
        mode_next         = mode_reg;
        blink_period_next = blink_period_reg;
        if (wr_accept) begin
            case (wr_word)
                WORD_CTRL:  ctrl_next = CTRL_W'(byte_merge(DW'(ctrl_reg), S_AXI_WDATA, S_AXI_WSTRB));
                WORD_MODE:  mode_next = MODE_W'(byte_merge(DW'(mode_reg), S_AXI_WDATA, S_AXI_WSTRB));
                WORD_BLINK: blink_period_next =
                                BLINK_W'(byte_merge(DW'(blink_period_reg), S_AXI_WDATA, S_AXI_WSTRB));
                default: ;
            endcase
        end

        // PWM counter simply wraps at 2^DUTY_W.
        cnt_next = cnt_reg + 1'b1;

        // Blink prescaler. Period 0 parks the phase high; a period write
        // restarts the count but leaves the phase alone.
        presc_next = presc_reg;
        phase_next = phase_reg;
        if (blink_period_reg == '0) begin
            presc_next = '0;
            phase_next = 1'b1;
        end else if (bp_wr) begin
            presc_next = '0;
        end else if (presc_reg == blink_period_reg - 1'b1) begin
            presc_next = '0;
            phase_next = ~phase_reg;
        end else begin
            presc_next = presc_reg + 1'b1;
        end

        // Write response
        bvalid_next = bvalid_reg;
        bresp_next  = bresp_reg;
        if (wr_accept) begin
            bvalid_next = 1'b1;
            bresp_next  = wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_reg && S_AXI_BREADY) begin
            bvalid_next = 1'b0;
        end

        // Read response
        rvalid_next = rvalid_reg;
        rresp_next  = rresp_reg;
        rdata_next  = rdata_reg;
        if (rd_accept) begin
            rvalid_next = 1'b1;
            rresp_next  = rd_hit ? RESP_OKAY : RESP_SLVERR;
            rdata_next  = rd_data;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_next = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_reg         <= '0;
            mode_reg         <= '0;
            blink_period_reg <= '0;
            presc_reg        <= '0;
            phase_reg        <= 1'b1;
            cnt_reg          <= '0;
            led_reg          <= '0;
            bvalid_reg       <= 1'b0;
            bresp_reg        <= RESP_OKAY;
            rvalid_reg       <= 1'b0;
            rresp_reg        <= RESP_OKAY;
            rdata_reg        <= '0;
        end else begin
            ctrl_reg         <= ctrl_next;
            mode_reg         <= mode_next;
            blink_period_reg <= blink_period_next;
            presc_reg        <= presc_next;
            phase_reg        <= phase_next;
            cnt_reg          <= cnt_next;
            led_reg          <= led_next;
            bvalid_reg       <= bvalid_next;
            bresp_reg        <= bresp_next;
            rvalid_reg       <= rvalid_next;
            rresp_reg        <= rresp_next;
            rdata_reg        <= rdata_next;
        end
    end

endmodule

// File: tb/tb_axi_led_pwm_ctrl.sv
// ============================================================================
// tb_axi_led_pwm_ctrl
// ----------------------------------------------------------------------------
// Drives directed and randomized AXI4-Lite traffic into axi_led_pwm_ctrl.
// A behavioural model (register file as an array of words, PWM position as
// cycle-count modulo period) predicts every output; a negedge process compares
// the DUT against it each cycle. Directed sections add literal expectations.
// ============================================================================
module tb_axi_led_pwm_ctrl;

    localparam int NUM_LED = 4;
    localparam int DUTY_W  = 8;
    localparam int BLINK_W = 24;
    localparam int AW      = 6;
    localparam int PERIOD  = 1 << DUTY_W;
    localparam int NWORDS  = 4 + NUM_LED;
    localparam int TMO     = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [NUM_LED-1:0] led;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_led_pwm_ctrl #(
        .NUM_LED(NUM_LED), .DUTY_W(DUTY_W), .BLINK_W(BLINK_W),
        .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
        .IRQ(irq),
`endif
        .LED(led)
    );

`ifndef AXI_LED_PWM_CTRL_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0]        m_regs [16];
    int                 m_shadow [NUM_LED];
    longint             m_cyc;
    int                 m_presc;
    bit                 m_phase, m_pend, m_irq;
    logic [NUM_LED-1:0] m_led;
    bit                 m_bvalid, m_rvalid;
    logic [1:0]         m_bresp, m_rresp;
    logic [31:0]        m_rdata;

    // model temporaries
    int                 t_pos, t_w, t_bp, t_md;
    bit                 t_wr, t_toggle, t_clr, t_pwm, t_irq;
    logic [NUM_LED-1:0] t_led;
    logic [31:0]        t_bmask;

    function automatic logic [31:0] reg_mask(input int w);
        case (w)
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
            0: return 32'h3;
`else
            0: return 32'h1;
`endif
            1: return (32'h1 << (2 * NUM_LED)) - 1;
            2: return (32'h1 << BLINK_W) - 1;
            default: return (32'h1 << DUTY_W) - 1;
        endcase
    endfunction

    function automatic logic [31:0] model_read_data(input int w);
        if (w >= NWORDS) return 32'h0;
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
        if (w == 3) return {30'h0, m_pend, m_phase};
`else
        if (w == 3) return {31'h0, m_phase};
`endif
        return m_regs[w];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 16; w++) m_regs[w] = 32'h0;
            for (int i = 0; i < NUM_LED; i++) m_shadow[i] = 0;
            m_cyc = 0; m_presc = 0; m_phase = 1'b1; m_pend = 1'b0; m_irq = 1'b0;
            m_led = '0; m_bvalid = 1'b0; m_bresp = 2'b00;
            m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
        end else begin
            // reads see the register file before this cycle's write
            if (arvalid && !m_rvalid) begin
                t_w      = int'(araddr[AW-1:2]);
                m_rvalid = 1'b1;
                m_rdata  = model_read_data(t_w);
                m_rresp  = (t_w < NWORDS) ? 2'b00 : 2'b10;
            end else if (m_rvalid && rready) begin
                m_rvalid = 1'b0;
            end

            t_pos = int'(m_cyc % PERIOD);
            for (int i = 0; i < NUM_LED; i++) begin
                t_md     = int'((m_regs[1] >> (2 * i)) & 32'h3);
                t_pwm    = (t_pos < m_shadow[i]);
                t_led[i] = m_regs[0][0] && ((t_md == 1 && t_pwm) || (t_md == 2 && t_pwm && m_phase));
            end
            t_irq = m_pend && m_regs[0][1];

            t_wr = awvalid && wvalid && !m_bvalid;
            t_w  = int'(awaddr[AW-1:2]);

            t_bp = int'(m_regs[2]);
            t_toggle = 1'b0;
            if (t_bp == 0) begin
                m_presc = 0; m_phase = 1'b1;
            end else if (t_wr && t_w == 2) begin
                m_presc = 0;
            end else if (m_presc == t_bp - 1) begin
                m_presc = 0; m_phase = !m_phase; t_toggle = 1'b1;
            end else begin
                m_presc++;
            end

            if (t_pos == PERIOD - 1)
                for (int i = 0; i < NUM_LED; i++) m_shadow[i] = int'(m_regs[4 + i]);

            t_clr = t_wr && t_w == 3 && wstrb[0] && wdata[1];
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
            if (t_toggle) m_pend = 1'b1;
            else if (t_clr) m_pend = 1'b0;
`endif

            if (t_wr) begin
                m_bvalid = 1'b1;
                if (t_w < NWORDS) begin
                    m_bresp = 2'b00;
                    if (t_w != 3) begin
                        for (int b = 0; b < 4; b++) t_bmask[8*b +: 8] = {8{wstrb[b]}};
                        m_regs[t_w] = ((m_regs[t_w] & ~t_bmask) | (wdata & t_bmask)) & reg_mask(t_w);
                    end
                end else begin
                    m_bresp = 2'b10;
                end
            end else if (m_bvalid && bready) begin
                m_bvalid = 1'b0;
            end

            m_led = t_led;
            m_irq = t_irq;
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("led", 32'(led), 32'(m_led));
            chk("awready", 32'(awready), 32'(awvalid && wvalid && !m_bvalid));
            chk("wready", 32'(wready), 32'(awvalid && wvalid && !m_bvalid));
            chk("arready", 32'(arready), 32'(arvalid && !m_rvalid));
            chk("bvalid", 32'(bvalid), 32'(m_bvalid));
            chk("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (m_bvalid) chk("bresp", 32'(bresp), 32'(m_bresp));
            if (m_rvalid) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", 32'(rresp), 32'(m_rresp));
            end
`ifdef AXI_LED_PWM_CTRL_IRQ_EN
            chk("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < TMO) begin n++; @(negedge clk); end
        chk("aw_handshake", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (bdelay) begin @(posedge clk); #1; end
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < TMO) begin n++; @(negedge clk); end
        chk("b_handshake", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
        $display("WR addr=%02h data=%08h strb=%h resp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin n++; @(negedge clk); end
        chk("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (rdelay) begin @(posedge clk); #1; end
        rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < TMO) begin n++; @(negedge clk); end
        chk("r_handshake", 32'(rvalid), 32'd1);
        data = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
        $display("RD addr=%02h data=%08h resp=%0d", addr, data, resp);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, 0, r);
        chk("wr_okay", 32'(r), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        int cnt, hi_other, n;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_bvalid", 32'(bvalid), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);

        // Reset readback
        for (int w = 0; w < NWORDS; w++) begin
            if (w == 3) continue;
            axi_read(AW'(4 * w), 0, d, r);
            chk("reset_read_data", d, 32'h0);
            chk("reset_read_resp", 32'(r), 32'd0);
        end

        // 50% duty on channel 0
        wr(6'h10, 32'h80);
        wr(6'h04, 32'h01);
        wr(6'h00, 32'h01);
        repeat (300) @(negedge clk);
        cnt = 0; hi_other = 0;
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            cnt += int'(led[0]);
            if (led[3:1] != 3'b000) hi_other++;
        end
        chk("pwm50_high_cycles", 32'(cnt), 32'd128);
        chk("pwm50_other_leds", 32'(hi_other), 32'd0);

        // Zero strobes leave the register alone; unmapped address errors
        axi_write(6'h10, 32'hFF, 4'h0, 0, r);
        chk("strb0_bresp", 32'(r), 32'd0);
        axi_read(6'h10, 0, d, r);
        chk("strb0_readback", d, 32'h80);
        axi_write(6'h3C, 32'h1234_5678, 4'hF, 0, r);
        chk("unmapped_bresp", 32'(r), 32'd2);
        axi_read(6'h3C, 0, d, r);
        chk("unmapped_rresp", 32'(r), 32'd2);
        chk("unmapped_rdata", d, 32'h0);

        // Blink: 10 cycles on, 10 off
        wr(6'h08, 32'd10);
        wr(6'h04, 32'h02);
        wr(6'h10, 32'hFF);
        wr(6'h00, 32'h01);
        repeat (300) @(negedge clk);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            cnt += int'(led[0]);
        end
        checks++;
        if (cnt != 100 && cnt != 99) begin
            failures++;
            $display("FAIL blink_high_cycles actual=%0d expected=99..100", cnt);
        end

        // Write and read in the same cycle: read returns the old value
        fork
            axi_write(6'h04, 32'h05, 4'hF, 0, r);
            axi_read(6'h04, 0, d, r2);
        join
        chk("same_cycle_old_value", d, 32'h02);
        axi_read(6'h04, 0, d, r);
        chk("same_cycle_new_value", d, 32'h05);

        // Back-pressure on the write response
        @(posedge clk); #1;
        awaddr = 6'h14; wdata = 32'h40; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("bp_first_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awaddr = 6'h18; wdata = 32'h33;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_bvalid_held", 32'(bvalid), 32'd1);
            chk("bp_second_blocked", 32'(awready), 32'd0);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("bp_second_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        $display("WR addr=14 data=00000040 strb=f (held response)");
        $display("WR addr=18 data=00000033 strb=f (queued behind held response)");
        axi_read(6'h18, 0, d, r);
        chk("bp_second_data", d, 32'h33);

`ifdef AXI_LED_PWM_CTRL_IRQ_EN
        wr(6'h00, 32'h03);
        wr(6'h08, 32'd5);
        n = 0;
        @(negedge clk);
        while (!irq && n < 7) begin n++; @(negedge clk); end
        chk("irq_rise", 32'(irq), 32'd1);
        wr(6'h08, 32'd1000);
        wr(6'h0C, 32'h02);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 1010) begin n++; @(negedge clk); end
        chk("irq_reassert", 32'(irq), 32'd1);
`endif

        // Randomized traffic
        for (int k = 0; k < 250; k++) begin
            int op, w;
            logic [AW-1:0] a;
            logic [31:0] dat;
            op  = int'($urandom_range(0, 9));
            w   = int'($urandom_range(0, 15));
            a   = AW'(4 * w + int'($urandom_range(0, 3)));
            dat = $urandom;
            if (w == 2) dat = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 25));
            if (op <= 4) begin
                axi_write(a, dat, 4'($urandom), int'($urandom_range(0, 4)), r);
            end else if (op <= 8) begin
                axi_read(a, int'($urandom_range(0, 4)), d, r);
            end else begin
                fork
                    axi_write(a, dat, 4'hF, int'($urandom_range(0, 2)), r);
                    axi_read(AW'(4 * int'($urandom_range(0, 15))), int'($urandom_range(0, 2)), d2, r2);
                join
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Reset while a read and a write response are pending
        @(posedge clk); #1;
        araddr = 6'h00; arvalid = 1'b1; awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
        chk("pre_reset_bvalid", 32'(bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rvalid", 32'(rvalid), 32'd0);
        chk("async_reset_bvalid", 32'(bvalid), 32'd0);
        chk("async_reset_led", 32'(led), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        axi_read(6'h00, 0, d, r);
        chk("post_reset_ctrl", d, 32'h0);
        axi_read(6'h10, 0, d, r);
        chk("post_reset_duty", d, 32'h0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
